// File: rtl/seven_segment_scan.sv
// Time-multiplexed common-anode seven-segment scanner for DIGITS digits, with a refresh
// prescaler, per-digit blank/dp and an anode guard interval. Optional macro: SEVSEG_LZ_BLANK_EN.
module seven_segment_scan #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 17,
  parameter int GUARD  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_nums,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [6:0]            o_seg,
  output logic                  o_dp_out,
  output logic [DIGITS-1:0]     o_sel
);

  localparam int               IDX_W   = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;  4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;  4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;  4'hE: glyph = 7'h4F;  default: glyph = 7'h47;
    endcase
  endfunction

  logic [DIV_W-1:0]  r_pcnt;
  logic [DIV_W-1:0]  r_gcnt;
  logic [IDX_W-1:0]  r_idx;

  logic              w_tick;
  logic [IDX_W-1:0]  w_nidx;
  logic [3:0]        w_code;
  logic              w_sup;
  logic              w_hide;
  logic [DIGITS-1:0] w_sel_new;
  logic [DIGITS-1:0] w_sel_cur;

  assign w_tick    = &r_pcnt;
  assign w_nidx    = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  assign w_code    = i_nums[{w_nidx, 2'b00} +: 4];
  assign w_sel_new = ~(DIGITS'(1) << w_nidx);
  assign w_sel_cur = ~(DIGITS'(1) << r_idx);

`ifdef SEVSEG_LZ_BLANK_EN
  // Digit i is suppressed when it and every more significant digit are zero.
  logic [DIGITS-1:0] w_lz;
  logic              w_run;
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_run   = w_run & (i_nums[4*i +: 4] == 4'h0);
      w_lz[i] = w_run;
    end
  end
  assign w_sup = w_lz[w_nidx];
`else
  assign w_sup = 1'b0;
`endif

  assign w_hide = i_blank[w_nidx] | w_sup;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_pcnt   <= '0;
      r_gcnt   <= '0;
      r_idx    <= LAST;
      o_sel    <= '1;
      o_seg    <= '0;
      o_dp_out <= 1'b0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
      if (w_tick) begin
        r_idx    <= w_nidx;
        r_gcnt   <= GUARD_V;
        o_seg    <= w_hide ? 7'h00 : glyph(w_code);
        o_dp_out <= i_dp[w_nidx] & ~i_blank[w_nidx];
        // Without a guard the anode switches together with the segments.
        o_sel    <= (GUARD == 0) ? w_sel_new : '1;
      end else if (r_gcnt != '0) begin
        r_gcnt <= r_gcnt - 1'b1;
        if (r_gcnt == DIV_W'(1)) o_sel <= w_sel_cur;
      end
    end
  end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Parametrised time-multiplexed driver for common-anode seven-segment displays with N digits. It generalises the fixed four-digit scanner to any digit count and adds several display controls: a programmable refresh prescaler, per-digit blanking, decimal points and an anti-ghosting guard interval. It sits between the application datapath (packed hex nibbles) and the board's segment/anode pins.

## Interface
- `DIGITS`, default 4: number of digits scanned, 2..16.
- `DIV_W`, default 17: prescaler width; one digit slot lasts 2**DIV_W clk cycles.
- `GUARD`, default 4: cycles with all anodes off at the start of each slot; must satisfy 0 <= GUARD < 2**DIV_W - 1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; low blanks the display and holds the scanner in its reset state.
- `nums`  in  4*DIGITS  packed hex codes; digit i = nums[4i+3:4i]; digit 0 is rightmost.
- `blank`  in  DIGITS  per-digit force-blank (1 = segments off).
- `dp`  in  DIGITS  per-digit decimal point request.
- `seg`  out  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-high, registered.
- `dp_out`  out  1  decimal point of the current digit, active-high, registered.
- `sel`  out  DIGITS  anode selects, active-low one-cold; sel[i] drives digit i. Registered.

## Operation
- Prescaler `pcnt` (DIV_W bits) increments every cycle while en=1 and wraps at all-ones. `tick` = (pcnt == all-ones).
- Digit index `idx` (clog2(DIGITS) bits, minimum 1) resets to DIGITS-1. On each tick it advances: idx = DIGITS-1 wraps to 0, otherwise idx+1. The first slot after reset therefore shows digit 0, and scan order is 0,1,...,DIGITS-1,0,...
- On the tick edge the block loads three things:
  - `seg` with the glyph of nums[new idx]; `nums` is sampled only at this edge.
  - `dp_out` with dp[new idx].
  - `sel` with all ones, which starts the guard interval.
- After the guard, the block drives `sel` to the one-cold code of idx, with bit idx low.
- Glyphs for codes 0..F (hex): 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B, 77, 1F, 4E, 3D, 4F, 47.
- If blank[idx] is set at load, seg=0 and dp_out=0. `sel` still activates, so the duty cycle stays uniform.
- Guard counter `gcnt` loads GUARD at the tick and decrements to 0. `sel` activates on the edge where gcnt becomes 0. With GUARD=0, `sel` activates on the tick edge itself.
- en=0 or rst=1 forces the same values, on the next edge:
  - pcnt=0, gcnt=0, idx=DIGITS-1;
  - sel all ones, seg=0, dp_out=0.
- rst has priority over en. Reset or a disable in mid-slot or mid-guard aborts the slot immediately with no partial anode pulse. Scanning restarts from digit 0.
- Changes to blank or dp in mid-slot take effect at the next load.

## Timing
- Reset values: seg=7'h00, dp_out=0, sel={DIGITS{1'b1}}; internal pcnt=0, gcnt=0, idx=DIGITS-1.
- The first load edge is the 2**DIV_W-th rising edge after rst falls with en=1. `sel` activates GUARD edges later.
- Slot period is exactly 2**DIV_W cycles. A digit's anode is low for 2**DIV_W - GUARD cycles per frame, and the frame period is DIGITS*2**DIV_W cycles.
- Latency from a nums change to display is at most DIGITS*2**DIV_W cycles (next visit of that digit).
- At most one sel bit is low in any cycle. Anodes never overlap and never change on the same edge as seg, except when GUARD=0.

## Configuration
- `SEVSEG_LZ_BLANK_EN` enables leading-zero suppression.
- Defined: at load, digit i (i > 0) is blanked when nums digits i..DIGITS-1 are all zero. Digit 0 is never suppressed, and dp still shows for suppressed digits unless blank[i] is set. Suppression is evaluated on the nums value sampled at that load edge.
- Undefined: zero codes display glyph 7E like any other code. No extra logic is synthesised.

## Test plan
All scenarios use DIGITS=4, DIV_W=4, GUARD=2.

- **Reset and first slot:** rst high 3 cycles, then low with en=1 and nums=16'h1234.
  - seg=00 and sel=F until edge 16.
  - Edge 16: seg=7E? No: seg=33 (digit 0 = 4), and sel=F.
  - Edge 18: sel=E.
- **Full scan order:** nums=16'hA5C0, run 64+ cycles. Loads give seg 7E, 4E, 5B, 77 for digits 0..3, with sel E, D, B, 7 in turn. Exactly one anode is low per cycle. The guard has sel=F for 2 cycles every 16.
- **Blank and dp:** blank=4'b0010, dp=4'b0110. Digit 1 gives seg=00, dp_out=0 with sel=D still pulsed. Digit 2 gives dp_out=1.
- **Mid-slot disable:** drop en at cycle 8 of digit 2's slot. Next edge gives sel=F, seg=00. Raising en restarts at digit 0 after 16 cycles.
- **nums sampling:** change nums during digit 1's active window. seg holds until the next load of digit 1.
- **`SEVSEG_LZ_BLANK_EN`:** nums=16'h0050. Digits 3 and 2 give seg=00, digit 1 gives 5B, digit 0 gives 7E. With the macro undefined, digits 3 and 2 give 7E.
